// File: rtl/proc_seq_pkg.sv
// proc_seq_pkg: shared definitions for the processor stimulus sequencer.
// Holds the op encodings, the sequencer state enum and the helpers that
// locate each field inside a program entry:
//   [validBit] valid | [opBit] op | [addrLsb +: ADDR_W] addr | [DATA_W-1:0] data
package proc_seq_pkg;

  localparam logic OP_READ    = 1'b0;
  localparam logic OP_WRITE   = 1'b1;
  localparam int   LOOP_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_WAIT_RESP,
    ST_DONE
  } seqState_e;

  function automatic int instrWidth(input int addrW, input int dataW);
    return 2 + addrW + dataW;
  endfunction

  function automatic int validBit(input int addrW, input int dataW);
    return 1 + addrW + dataW;
  endfunction

  function automatic int opBit(input int addrW, input int dataW);
    return addrW + dataW;
  endfunction

  function automatic int addrLsb(input int dataW);
    return dataW;
  endfunction

endpackage

// File: rtl/proc_seq_gen_mem.sv
// proc_prog_mem: program store for proc_seq_gen.
// DEPTH x INSTR_W, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives rst_n.
// Ports:
//   clk    clock
//   we     write strobe (already qualified by the sequencer)
//   waddr  write index
//   wdata  entry to store
//   raddr  read index (the sequencer pc)
//   rdata  entry at raddr, combinational
module proc_prog_mem #(
  parameter int DEPTH   = 9,
  parameter int INSTR_W = 18,
  parameter int PC_W    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_seq_gen.sv
// proc_seq_gen: per-processor stimulus sequencer for the coherence system.
// Runs a loadable program of read/write operations against its cache
// controller over a valid/ready request channel, waits for read data and
// reports completion.
// Optional feature macro: PROC_SEQ_LOOP_EN -- the program repeats forever
// and the loop_cnt output counts completed passes (saturating).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                pulse: run program from entry 0 (IDLE/DONE only)
//   prog_we/addr/wdata   program load port (IDLE/DONE only, addr < DEPTH)
//   req_valid/ready      request handshake
//   req_op/addr/data     request payload (data is 0 for reads)
//   req_src              constant PROC_ID
//   resp_valid/data      read response
//   last_rdata           most recent accepted read data
//   busy, done           running / finished (done sticky until start)
//   err_stray            sticky: response seen outside WAIT_RESP
//   pc                   current program index
//   loop_cnt             completed passes (PROC_SEQ_LOOP_EN only)
module proc_seq_gen
  import proc_seq_pkg::*;
#(
  parameter  int ADDR_W  = 8,
  parameter  int DATA_W  = 8,
  parameter  int DEPTH   = 9,
  parameter  int PROC_ID = 0,
  localparam int PC_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int INSTR_W = instrWidth(ADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_op,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [DATA_W-1:0]  req_data,
  output logic [1:0]         req_src,
  input  logic               resp_valid,
  input  logic [DATA_W-1:0]  resp_data,
  output logic [DATA_W-1:0]  last_rdata,
  output logic               busy,
  output logic               done,
  output logic               err_stray,
`ifdef PROC_SEQ_LOOP_EN
  output logic [LOOP_CNT_W-1:0] loop_cnt,
`endif
  output logic [PC_W-1:0]    pc
);

  localparam int VALID_B = validBit(ADDR_W, DATA_W);
  localparam int OP_B    = opBit(ADDR_W, DATA_W);
  localparam int ADDR_L  = addrLsb(DATA_W);

  seqState_e          state, stateNext;
  logic [INSTR_W-1:0] instr;
  logic               idleLike, memWe, lastEntry;
  logic               startRun, latchReq, handshake, advance;

  assign idleLike  = (state == ST_IDLE) || (state == ST_DONE);
  // Loads land before FETCH reads, so a load in the start cycle is seen.
  assign memWe     = prog_we && idleLike && (int'(prog_addr) < DEPTH);
  assign lastEntry = (int'(pc) == DEPTH - 1);
  assign busy      = (state == ST_FETCH) || (state == ST_REQ) || (state == ST_WAIT_RESP);
  assign handshake = (state == ST_REQ) && req_valid && req_ready;
  assign req_src   = 2'(PROC_ID);

  proc_prog_mem #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) uMem (
    .clk   (clk),
    .we    (memWe),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc),
    .rdata (instr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    startRun  = 1'b0;
    latchReq  = 1'b0;
    advance   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) begin
        startRun  = 1'b1;
        stateNext = ST_FETCH;
      end
      ST_FETCH: if (instr[VALID_B]) begin
        latchReq  = 1'b1;
        stateNext = ST_REQ;
      end else begin
        advance = 1'b1;
      end
      ST_REQ: if (handshake) begin
        if (req_op == OP_WRITE) advance = 1'b1;
        else                    stateNext = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: if (resp_valid) advance = 1'b1;
      default: stateNext = ST_IDLE;
    endcase
    if (advance) begin
`ifdef PROC_SEQ_LOOP_EN
      stateNext = ST_FETCH;
`else
      stateNext = lastEntry ? ST_DONE : ST_FETCH;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= '0;
      req_valid  <= 1'b0;
      req_op     <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      last_rdata <= '0;
      done       <= 1'b0;
      err_stray  <= 1'b0;
`ifdef PROC_SEQ_LOOP_EN
      loop_cnt   <= '0;
`endif
    end else begin
      if (resp_valid && (state != ST_WAIT_RESP)) err_stray <= 1'b1;
      if (startRun) begin
        pc        <= '0;
        done      <= 1'b0;
        err_stray <= 1'b0;
`ifdef PROC_SEQ_LOOP_EN
        loop_cnt  <= '0;
`endif
      end
      if (latchReq) begin
        req_valid <= 1'b1;
        req_op    <= instr[OP_B];
        req_addr  <= instr[ADDR_L +: ADDR_W];
        req_data  <= (instr[OP_B] == OP_WRITE) ? instr[DATA_W-1:0] : '0;
      end
      if (handshake) req_valid <= 1'b0;
      if ((state == ST_WAIT_RESP) && resp_valid) last_rdata <= resp_data;
      if (advance) begin
        if (!lastEntry) begin
          pc <= pc + 1'b1;
        end else begin
`ifdef PROC_SEQ_LOOP_EN
          pc <= '0;
          if (loop_cnt != '1) loop_cnt <= loop_cnt + 1'b1;
`else
          done <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_seq_gen.sv
// tb_proc_seq_gen: self-checking bench for proc_seq_gen (default build).
// Keeps a plain array copy of the program; the expected request stream is
// every valid entry in order, and the expected run length is one FETCH per
// entry, one REQ cycle per valid entry, plus every stall and response wait
// the bench itself injected.
module tb_proc_seq_gen;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 9;
  localparam int PROC_ID = 2;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 18;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, prog_we = 1'b0;
  logic [PC_W-1:0]    prog_addr = '0;
  logic [INSTR_W-1:0] prog_wdata = '0;
  logic req_valid, req_op;
  logic req_ready = 1'b0;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data, last_rdata;
  logic [1:0] req_src;
  logic resp_valid = 1'b0;
  logic [DATA_W-1:0] resp_data = '0;
  logic busy, done, err_stray;
  logic [PC_W-1:0] pc;
`ifdef PROC_SEQ_LOOP_EN
  logic [15:0] loop_cnt;
`endif

  int vectors = 0, miscompares = 0;

  bit         mv  [DEPTH];
  bit         mop [DEPTH];
  logic [7:0] ma  [DEPTH];
  logic [7:0] md  [DEPTH];
  logic [7:0] expRd = '0;
  logic [16:0] obsQ[$];
  int cycles, extraCyc;

  proc_seq_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PROC_ID(PROC_ID)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_src(req_src), .resp_valid(resp_valid),
    .resp_data(resp_data), .last_rdata(last_rdata), .busy(busy), .done(done),
    .err_stray(err_stray),
`ifdef PROC_SEQ_LOOP_EN
    .loop_cnt(loop_cnt),
`endif
    .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_vld"},  req_valid, 0);
    chk({tag, "_req"},  {req_op, req_addr, req_data}, 0);
    chk({tag, "_rd"},   last_rdata, 0);
    chk({tag, "_flag"}, {busy, done, err_stray}, 0);
    chk({tag, "_pc"},   pc, 0);
    chk({tag, "_src"},  req_src, PROC_ID);
  endtask

  task automatic writeEntry(input int i, input bit v, input bit op, input logic [7:0] a,
                            input logic [7:0] d);
    prog_we = 1'b1; prog_addr = PC_W'(i); prog_wdata = {v, op, a, d};
    step();
    prog_we = 1'b0;
    if (i < DEPTH) begin mv[i] = v; mop[i] = op; ma[i] = a; md[i] = d; end
  endtask

  task automatic randProg(input int validPct, input logic [DEPTH-1:0] forceInv);
    for (int i = 0; i < DEPTH; i++)
      writeEntry(i, !forceInv[i] && ($urandom_range(99) < validPct), 1'($urandom_range(1)),
                 8'($urandom), 8'($urandom));
  endtask

  // Drives random back-pressure, delayed responses and ignored start/prog_we
  // noise until done, checking request stability under stalls.
  task automatic runLoop(input int readyPct);
    bit pend = 0, pv = 0, fin = 0;
    int waitN = 0;
    logic [7:0] rd = '0;
    logic [16:0] pf = '0;
    logic [PC_W-1:0] ppc = '0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (done) fin = 1;
      else begin
        cycles++;
        if (pv) begin
          chk("stall_hold", {req_valid, req_op, req_addr, req_data}, {1'b1, pf});
          chk("stall_pc", pc, ppc);
        end
        resp_valid = 1'b0;
        if (pend) begin
          if (waitN == 0) begin resp_valid = 1'b1; resp_data = rd; expRd = rd; pend = 0; end
          else waitN--;
        end
        req_ready  = ($urandom_range(99) < readyPct);
        start      = ($urandom_range(3) == 0);
        prog_we    = 1'($urandom_range(1));
        prog_addr  = PC_W'($urandom);
        prog_wdata = INSTR_W'($urandom);
        pv = 0;
        if (req_valid) begin
          if (req_ready) begin
            obsQ.push_back({req_op, req_addr, req_data});
            if (!req_op) begin
              pend = 1; waitN = $urandom_range(3); rd = 8'($urandom); extraCyc += waitN + 1;
            end
          end else begin
            pv = 1; pf = {req_op, req_addr, req_data}; ppc = pc; extraCyc++;
          end
        end
        step();
      end
    end
    req_ready = 1'b0; resp_valid = 1'b0; start = 1'b0; prog_we = 1'b0;
    chk("done_reached", 32'(fin), 1);
  endtask

  task automatic runProg(input int readyPct, input bit wrStart, input string tag);
    logic [16:0] expQ[$];
    int nv = 0;
    obsQ.delete(); cycles = 0; extraCyc = 0;
    if (wrStart) begin
      mv[0] = 1; mop[0] = 1'($urandom_range(1)); ma[0] = 8'($urandom); md[0] = 8'($urandom);
      prog_we = 1'b1; prog_addr = '0; prog_wdata = {mv[0], mop[0], ma[0], md[0]};
    end
    start = 1'b1;
    step();
    start = 1'b0; prog_we = 1'b0;
    chk({tag, "_start"}, {busy, done, err_stray, req_valid}, 4'b1000);
    for (int i = 0; i < DEPTH; i++)
      if (mv[i]) begin expQ.push_back({mop[i], ma[i], mop[i] ? md[i] : 8'h00}); nv++; end
    runLoop(readyPct);
    chk({tag, "_nreq"}, obsQ.size(), nv);
    for (int i = 0; i < nv && i < obsQ.size(); i++) chk({tag, "_req"}, obsQ[i], expQ[i]);
    chk({tag, "_cycles"}, cycles, DEPTH + nv + extraCyc);
    chk({tag, "_rdata"}, last_rdata, expRd);
    chk({tag, "_end"}, {busy, done, pc}, {2'b01, PC_W'(DEPTH - 1)});
  endtask

  initial begin
    // Reset values
    step(); step();
    chkReset("reset");
    rst_n = 1'b1;
    expRd = '0;

    // Stray response in IDLE
    resp_valid = 1'b1; resp_data = 8'h5A;
    step();
    resp_valid = 1'b0;
    chk("stray_idle", {err_stray, last_rdata}, {1'b1, 8'h00});

    // Write 0x05<-0x78 then read 0x05, with a 5-cycle stall on the write
    for (int i = 0; i < DEPTH; i++) writeEntry(i, 0, 0, 8'h00, 8'h00);
    writeEntry(0, 1, 1, 8'h05, 8'h78);
    writeEntry(1, 1, 0, 8'h05, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("a_lat1", {err_stray, busy, req_valid}, 3'b010);
    step();
    chk("a_lat2", {req_valid, req_op, req_addr, req_data}, {1'b1, 1'b1, 8'h05, 8'h78});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("a_stall", {req_valid, req_op, req_addr, req_data, pc}, {2'b11, 8'h05, 8'h78, 4'd0});
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("a_wr_hs", {req_valid, pc}, {1'b0, 4'd1});
    step();
    chk("a_rd_req", {req_valid, req_op, req_addr, req_data}, {2'b10, 8'h05, 8'h00});
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    step(); step();
    resp_valid = 1'b1; resp_data = 8'hAB;
    step();
    resp_valid = 1'b0;
    expRd = 8'hAB;
    chk("a_rdata", {last_rdata, pc}, {8'hAB, 4'd2});
    begin
      int c = 0;
      while (!done && c < 20) begin step(); c++; end
      chk("a_bubbles", c, 7);
    end
    chk("a_done", {busy, done}, 2'b01);

    // Stray response while a request is pending
    start = 1'b1; step(); start = 1'b0;
    step();
    resp_valid = 1'b1; resp_data = 8'h33;
    step();
    resp_valid = 1'b0;
    chk("stray_req", {err_stray, req_valid, last_rdata}, {2'b11, 8'hAB});
    obsQ.delete();
    runLoop(100);
    chk("stray_rdata", last_rdata, expRd);

    // Reset while waiting for a read response
    writeEntry(0, 1, 0, 8'h21, 8'h00);
    start = 1'b1; step(); start = 1'b0;
    step();
    req_ready = 1'b1; step(); req_ready = 1'b0;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chkReset("mid_rst");
    expRd = '0;
    runProg(100, 0, "rerun");

    // Out-of-range load is dropped; randomized programs
    writeEntry(12, 1, 1, 8'hFF, 8'hFF);
    for (int r = 0; r < 6; r++) begin
      randProg(70, '0);
      runProg((r % 3 == 0) ? 100 : ((r % 3 == 1) ? 60 : 30), r[0], "rand");
    end

    // Entries 1,4,5 invalid: six requests
    randProg(100, 9'b000110010);
    runProg(100, 0, "inv145");
    chk("inv145_cnt", obsQ.size(), 6);

    // All-invalid program
    randProg(0, '0);
    runProg(50, 0, "allinv");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
